// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter.
// A 16-entry FIFO absorbs bursts of up to one byte per clock.
// A four-state serializer drains the FIFO; when more data is waiting at the end
// of a stop bit, the next frame follows with no idle gap.
module uart_tx_buf #(
    parameter int CLK_DIV = 434,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [7:0]        i_data,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_full,
    output logic [ADDR_W:0]   o_level,
    output logic              o_drop
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                full_q, full_d;
    logic                drop_q, drop_d;
    logic [7:0]          mem [DEPTH];

    logic push, pop, baud_end, have_data;

    assign baud_end  = (baud_q == BAUD_LAST);
    assign have_data = (level_q != '0);

    // Serializer next state: o_tx is precomputed for the state being entered so
    // the line comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr_q];
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_d = mem[rptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO bookkeeping: acceptance uses the registered full flag, so a pop on
    // the same edge does not rescue a write that arrives while full.
    always_comb begin
        push   = i_en & ~full_q;
        drop_d = i_en & full_q;
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_FULL);
    end

    // Control and datapath registers; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr_q] <= i_data;
        end
    end

    assign o_tx    = tx_q;
    assign o_busy  = (state_q != S_IDLE);
    assign o_full  = full_q;
    assign o_level = level_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: a transaction-level model (byte queue plus a frame timer)
// predicts the level, full, drop, busy and line state after every clock edge.
module tb_uart_tx_buf;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_en = 1'b0;
    logic [7:0]    i_data = 8'h00;
    logic          o_tx, o_busy, o_full, o_drop;
    logic [AW:0]   o_level;

    uart_tx_buf #(.CLK_DIV(DIV), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_en),
        .i_data  (i_data),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_full  (o_full),
        .o_level (o_level),
        .o_drop  (o_drop)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: bytes waiting, plus the frame on the line (popped at edge cur_start,
    // occupying edges cur_start .. frame_end-1).
    logic [7:0] mq[$];
    int         k = 0;
    int         frame_end = 0;
    int         cur_start = 0;
    logic [7:0] cur_byte = 8'h00;
    logic       m_drop = 1'b0;
    int         pops = 0;

    // Observations accumulated over one test phase.
    int drops_seen, busy_cycles, peak_lvl, full_at, nsteps;

    logic [7:0] burst [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level after edge k: start bit, 8 data bits LSB first, stop bit.
    function automatic logic model_tx();
        int pos;
        if (k >= frame_end) return 1'b1;
        pos = k - cur_start;
        if (pos < DIV) return 1'b0;
        if (pos >= 9 * DIV) return 1'b1;
        return cur_byte[(pos - DIV) / DIV];
    endfunction

    task automatic clr_obs();
        drops_seen  = 0;
        busy_cycles = 0;
        peak_lvl    = 0;
        full_at     = -1;
        nsteps      = 0;
    endtask

    // One clock edge: drive inputs, advance the model, then compare everything.
    task automatic step(input logic r, input logic en, input logic [7:0] d);
        logic full_m;
        rst    = r;
        i_en   = en;
        i_data = d;
        k++;
        if (r) begin
            mq.delete();
            frame_end = 0;
            m_drop    = 1'b0;
        end else begin
            full_m = (mq.size() == DEPTH);
            if (mq.size() > 0 && k >= frame_end) begin
                cur_byte  = mq.pop_front();
                cur_start = k;
                frame_end = k + FRAME;
                pops++;
            end
            m_drop = en && full_m;
            if (en && !full_m) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        nsteps++;
        drops_seen  += int'(o_drop);
        busy_cycles += int'(o_busy);
        if (int'(o_level) > peak_lvl) peak_lvl = int'(o_level);
        if (o_full === 1'b1 && full_at < 0) full_at = nsteps;
        chk($sformatf("level@%0d", k), 32'(o_level), 32'(mq.size()));
        chk($sformatf("full@%0d", k), 32'(o_full), 32'(mq.size() == DEPTH));
        chk($sformatf("drop@%0d", k), 32'(o_drop), 32'(m_drop));
        chk($sformatf("busy@%0d", k), 32'(o_busy), 32'(k < frame_end));
        chk($sformatf("tx@%0d", k), 32'(o_tx), 32'(model_tx()));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && (k < frame_end || mq.size() > 0); n++) step(1'b0, 1'b0, 8'h00);
        idle(2);
        chk("drain_idle", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int cnt, p0, n;
        logic rr, ee;

        // Reset
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);

        // Single byte 0x01
        clr_obs();
        step(1'b0, 1'b1, 8'h01);
        idle(FRAME + 5);
        chk("t1_busy_len", 32'(busy_cycles), 32'(FRAME));
        chk("t1_busy_end", 32'(o_busy), 32'd0);
        chk("t1_level_end", 32'(o_level), 32'd0);

        // Eight-byte burst, back-to-back frames
        clr_obs();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, burst[i]);
        drain();
        chk("t2_peak", 32'(peak_lvl), 32'd7);
        chk("t2_drops", 32'(drops_seen), 32'd0);
        chk("t2_busy_len", 32'(busy_cycles), 32'(8 * FRAME));

        // Twenty-clock burst overruns the FIFO
        clr_obs();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(i));
        chk("t3_full_at", 32'(full_at), 32'd17);
        drain();
        chk("t3_drops", 32'(drops_seen), 32'd3);
        chk("t3_busy_len", 32'(busy_cycles), 32'(17 * FRAME));

        // Full FIFO with a pop due on the same edge as a write
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'($urandom));
        for (n = 0; n < 2 * FRAME && (k + 1 != frame_end); n++) step(1'b0, 1'b0, 8'h00);
        chk("t4_wait_stop", 32'(n < 2 * FRAME), 32'd1);
        chk("t4_lvl16", 32'(o_level), 32'd16);
        step(1'b0, 1'b1, 8'h5A);
        chk("t4_drop", 32'(o_drop), 32'd1);
        chk("t4_lvl15", 32'(o_level), 32'd15);
        for (n = 0; n < 20 * FRAME && !(mq.size() == 5 && k + 1 == frame_end); n++)
            step(1'b0, 1'b0, 8'h00);
        chk("t4_wait_lvl5", 32'(n < 20 * FRAME), 32'd1);
        chk("t4_lvl5_pre", 32'(o_level), 32'd5);
        step(1'b0, 1'b1, 8'hC3);
        chk("t4_lvl5_post", 32'(o_level), 32'd5);
        chk("t4_nodrop", 32'(o_drop), 32'd0);
        drain();

        // Reset in the middle of the second of three queued frames
        p0 = pops;
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        for (n = 0; n < 4 * FRAME && !(pops == p0 + 2 && k - cur_start == 5 * DIV); n++)
            step(1'b0, 1'b0, 8'h00);
        chk("t5_wait_mid", 32'(n < 4 * FRAME), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        chk("t5_tx", 32'(o_tx), 32'd1);
        chk("t5_level", 32'(o_level), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);
        clr_obs();
        idle(3 * FRAME);
        chk("t5_quiet", 32'(busy_cycles), 32'd0);
        step(1'b0, 1'b1, 8'hA5);
        idle(FRAME + 5);
        chk("t5_a5_len", 32'(busy_cycles), 32'(FRAME));

        // Pointer wrap: 40 bytes with gaps, never filling
        clr_obs();
        cnt = 0;
        for (n = 0; n < 8000 && cnt < 40; n++) begin
            if (mq.size() < 8 && $urandom_range(0, 15) == 0) begin
                step(1'b0, 1'b1, 8'($urandom));
                cnt++;
            end else begin
                step(1'b0, 1'b0, 8'h00);
            end
        end
        chk("t6_count", 32'(cnt), 32'd40);
        drain();
        chk("t6_drops", 32'(drops_seen), 32'd0);
        chk("t6_busy_len", 32'(busy_cycles), 32'(40 * FRAME));

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            ee = ($urandom_range(0, 2) == 0);
            step(rr, ee, 8'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
